// File: rtl/note_sequencer_pkg.sv
// note_pkg: shared sizes and state encoding for the sequencer, control FSM and HEX display.
package note_pkg;
    localparam int ADDR_W = 6;
    localparam int NOTE_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int PTR_W  = ADDR_W + 1;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_e;
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: command/beat inputs, RAM port and status outputs of the sequencer.
interface note_sequencer_if;
    import note_pkg::*;
    logic              beat;
    logic              start_record;
    logic              start_play;
    logic              stop;
    logic              loop_en;
    logic [NOTE_W-1:0] note_in;
    logic [NOTE_W-1:0] ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [NOTE_W-1:0] ram_data;
    logic [NOTE_W-1:0] note_out;
    logic [PTR_W-1:0]  rec_len;
    state_e            state;
    logic              done;
    logic              full;
    modport master (
        output beat, start_record, start_play, stop, loop_en, note_in, ram_q,
        input  ram_addr, ram_wren, ram_data, note_out, rec_len, state, done, full
    );
    modport slave (
        input  beat, start_record, start_play, stop, loop_en, note_in, ram_q,
        output ram_addr, ram_wren, ram_data, note_out, rec_len, state, done, full
    );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: beat-driven record/playback controller owning the note RAM port.
module note_sequencer
    import note_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    note_sequencer_if.slave  bus
);
    state_e            r_state, w_state;
    logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr, r_rd_ptr, w_rd_ptr, r_rec_len, w_rec_len;
    logic [PTR_W-1:0]  w_rd_inc;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [NOTE_W-1:0] r_data, w_data, r_note, w_note;
    logic              r_wren, w_wren, r_done, w_done, r_full, w_full;

    assign w_rd_inc = r_rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rec_len <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_note    <= '0;
            r_wren    <= 1'b0;
            r_done    <= 1'b0;
            r_full    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_wr_ptr  <= w_wr_ptr;
            r_rd_ptr  <= w_rd_ptr;
            r_rec_len <= w_rec_len;
            r_addr    <= w_addr;
            r_data    <= w_data;
            r_note    <= w_note;
            r_wren    <= w_wren;
            r_done    <= w_done;
            r_full    <= w_full;
        end
    end

    // Both REC and PLAY exit one cycle after their final beat, so the last write
    // and the last played note are seen in-state and done lands with IDLE.
    always_comb begin
        w_state   = r_state;
        w_wr_ptr  = r_wr_ptr;
        w_rd_ptr  = r_rd_ptr;
        w_rec_len = r_rec_len;
        w_addr    = r_addr;
        w_data    = r_data;
        w_note    = r_note;
        w_wren    = 1'b0;
        w_done    = 1'b0;
        w_full    = r_full;
        case (r_state)
            ST_IDLE: begin
                w_note = '0;
                if (bus.start_record) begin
                    w_state  = ST_REC;
                    w_wr_ptr = '0;
                    w_full   = 1'b0;
                end else if (bus.start_play) begin
                    if (r_rec_len != '0) begin
                        w_state  = ST_PLAY;
                        w_rd_ptr = '0;
                        w_addr   = '0;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            ST_REC: begin
                if (bus.stop || r_wr_ptr == PTR_W'(DEPTH)) begin
                    w_state   = ST_IDLE;
                    w_rec_len = r_wr_ptr;
                    w_full    = r_wr_ptr == PTR_W'(DEPTH);
                    w_done    = 1'b1;
                    w_note    = '0;
                end else if (bus.beat) begin
                    w_addr   = r_wr_ptr[ADDR_W-1:0];
                    w_data   = bus.note_in;
                    w_wren   = 1'b1;
                    w_note   = bus.note_in;
                    w_wr_ptr = r_wr_ptr + PTR_W'(1);
                end
            end
            ST_PLAY: begin
                if (bus.stop || r_rd_ptr == r_rec_len) begin
                    w_state = ST_IDLE;
                    w_done  = 1'b1;
                    w_note  = '0;
                end else if (bus.beat) begin
                    w_note   = bus.ram_q;
                    w_rd_ptr = (w_rd_inc == r_rec_len && bus.loop_en) ? '0 : w_rd_inc;
                    w_addr   = (w_rd_inc == r_rec_len && bus.loop_en) ? '0 : w_rd_inc[ADDR_W-1:0];
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    assign bus.ram_addr = r_addr;
    assign bus.ram_wren = r_wren;
    assign bus.ram_data = r_data;
    assign bus.note_out = r_note;
    assign bus.rec_len  = r_rec_len;
    assign bus.state    = r_state;
    assign bus.done     = r_done;
    assign bus.full     = r_full;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed record/play scenarios with a queue-based event scoreboard.
module tb_note_sequencer;
    import note_pkg::*;

    localparam logic [1:0] K_WR = 2'd0, K_DONE = 2'd1, K_NOTE = 2'd2;
    typedef struct {
        logic [1:0]  kind;
        logic [31:0] v;
        logic [6:0]  a;
    } ev_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ev_t  q[$];
    logic [31:0] mem [DEPTH];
    logic note_pend = 1'b0;

    note_sequencer_if bus();
    note_sequencer dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_addr];
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic take(logic [1:0] k, logic [31:0] v, logic [6:0] a, string nm);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event got v=%0h a=%0h expected none", nm, v, a);
        end else begin
            e = q.pop_front();
            chk({nm, " kind"}, 64'(k), 64'(e.kind));
            chk({nm, " a"}, 64'(a), 64'(e.a));
            chk({nm, " v"}, 64'(v), 64'(e.v));
        end
    endtask

    function automatic void push(logic [1:0] k, logic [31:0] v, logic [6:0] a);
        q.push_back('{k, v, a});
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            note_pend = 1'b0;
        end else begin
            if (note_pend) take(K_NOTE, bus.note_out, 7'd0, "note");
            if (bus.ram_wren) take(K_WR, bus.ram_data, 7'(bus.ram_addr), "write");
            if (bus.done) take(K_DONE, 32'({bus.full, bus.state}), bus.rec_len, "done");
            note_pend = bus.beat && !bus.stop && bus.state == ST_PLAY;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_done(logic [6:0] len, logic full);
        push(K_DONE, 32'({full, ST_IDLE}), len);
    endtask

    task automatic rec_beat(logic [31:0] n, logic [6:0] addr, bit fin);
        push(K_WR, n, addr);
        if (fin) push_done(7'd64, 1'b1);
        bus.note_in = n;
        bus.beat = 1'b1;
        tick(1);
        bus.beat = 1'b0;
        tick(3);
    endtask

    task automatic play_beat(logic [31:0] n, bit fin, logic [6:0] len);
        push(K_NOTE, n, 7'd0);
        if (fin) push_done(len, 1'b0);
        bus.beat = 1'b1;
        tick(1);
        bus.beat = 1'b0;
        tick(3);
    endtask

    task automatic pulse_rec();
        bus.start_record = 1'b1;
        tick(1);
        bus.start_record = 1'b0;
        tick(2);
    endtask

    task automatic pulse_play();
        bus.start_play = 1'b1;
        tick(1);
        bus.start_play = 1'b0;
        tick(2);
    endtask

    task automatic do_stop(logic [6:0] len, logic with_beat);
        push_done(len, 1'b0);
        bus.stop = 1'b1;
        bus.beat = with_beat;
        tick(1);
        bus.stop = 1'b0;
        bus.beat = 1'b0;
        tick(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.beat = 1'b0;
        bus.start_record = 1'b0;
        bus.start_play = 1'b0;
        bus.stop = 1'b0;
        bus.loop_en = 1'b0;
        bus.note_in = '0;
        tick(2);
        chk("rst state", 64'(bus.state), 64'(ST_IDLE));
        chk("rst rec_len", 64'(bus.rec_len), 0);
        chk("rst addr", 64'(bus.ram_addr), 0);
        chk("rst data", 64'(bus.ram_data), 0);
        chk("rst note_out", 64'(bus.note_out), 0);
        chk("rst wren", 64'(bus.ram_wren), 0);
        chk("rst done", 64'(bus.done), 0);
        chk("rst full", 64'(bus.full), 0);
        resetn = 1'b1;
        tick(2);

        // Empty playback: immediate done, no state change
        push_done(7'd0, 1'b0);
        bus.start_play = 1'b1;
        tick(1);
        bus.start_play = 1'b0;
        chk("empty play state", 64'(bus.state), 64'(ST_IDLE));
        chk("empty play wren", 64'(bus.ram_wren), 0);
        tick(2);

        // Record 3 notes; the beat coinciding with start_record is ignored
        bus.start_record = 1'b1;
        bus.beat = 1'b1;
        bus.note_in = 32'hdead;
        tick(1);
        bus.start_record = 1'b0;
        bus.beat = 1'b0;
        chk("rec state", 64'(bus.state), 64'(ST_REC));
        tick(3);
        rec_beat(32'h1, 7'd0, 1'b0);
        rec_beat(32'h40, 7'd1, 1'b0);
        rec_beat(32'h1000, 7'd2, 1'b0);
        do_stop(7'd3, 1'b0);
        chk("rec3 len", 64'(bus.rec_len), 3);
        chk("rec3 full", 64'(bus.full), 0);

        // One-shot playback
        pulse_play();
        chk("play state", 64'(bus.state), 64'(ST_PLAY));
        play_beat(32'h1, 1'b0, 7'd0);
        play_beat(32'h40, 1'b0, 7'd0);
        play_beat(32'h1000, 1'b1, 7'd3);
        chk("play end state", 64'(bus.state), 64'(ST_IDLE));
        chk("play end note", 64'(bus.note_out), 0);

        // Full recording of DEPTH notes, then an extra beat that must not write
        pulse_rec();
        for (int i = 0; i < DEPTH; i++)
            rec_beat(32'h100 + 32'(i), 7'(i), i == DEPTH - 1);
        chk("full flag", 64'(bus.full), 1);
        chk("full len", 64'(bus.rec_len), 64);
        chk("full state", 64'(bus.state), 64'(ST_IDLE));
        bus.beat = 1'b1;
        tick(1);
        bus.beat = 1'b0;
        tick(3);

        // Record 2, then stop together with a beat: no third write
        pulse_rec();
        chk("full cleared", 64'(bus.full), 0);
        rec_beat(32'h8, 7'd0, 1'b0);
        rec_beat(32'h80, 7'd1, 1'b0);
        do_stop(7'd2, 1'b1);
        chk("stop+beat len", 64'(bus.rec_len), 2);

        // Looped playback of 2 notes over 5 beats
        bus.loop_en = 1'b1;
        pulse_play();
        play_beat(32'h8, 1'b0, 7'd0);
        play_beat(32'h80, 1'b0, 7'd0);
        play_beat(32'h8, 1'b0, 7'd0);
        play_beat(32'h80, 1'b0, 7'd0);
        play_beat(32'h8, 1'b0, 7'd0);
        chk("loop state", 64'(bus.state), 64'(ST_PLAY));
        do_stop(7'd2, 1'b0);
        chk("loop stop state", 64'(bus.state), 64'(ST_IDLE));

        // Asynchronous reset in the middle of playback
        pulse_play();
        play_beat(32'h8, 1'b0, 7'd0);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst state", 64'(bus.state), 64'(ST_IDLE));
        chk("arst note_out", 64'(bus.note_out), 0);
        chk("arst addr", 64'(bus.ram_addr), 0);
        chk("arst rec_len", 64'(bus.rec_len), 0);
        @(negedge clk);
        resetn = 1'b1;
        tick(2);
        chk("post rst rec_len", 64'(bus.rec_len), 0);
        chk("post rst state", 64'(bus.state), 64'(ST_IDLE));
        push_done(7'd0, 1'b0);
        bus.start_play = 1'b1;
        tick(1);
        bus.start_play = 1'b0;
        tick(5);
        chk("queue empty", 64'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
